// File: rtl/sys_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sys_ctrl_pkg : shared state encoding and opcode constants for the      |
// |                system controller frame engine                          |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
package sys_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR_ADDR  = 4'd1,
        S_WR_DATA  = 4'd2,
        S_RD_ADDR  = 4'd3,
        S_RD_CNT   = 4'd4,
        S_RD_REQ   = 4'd5,
        S_RD_SEND  = 4'd6,
        S_OP_A     = 4'd7,
        S_OP_B     = 4'd8,
        S_ALU_FN   = 4'd9,
        S_ALU_RUN  = 4'd10,
        S_ALU_SEND = 4'd11
    } state_t;

    localparam logic [7:0] OPC_WR       = 8'hAA;
    localparam logic [7:0] OPC_RD       = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP   = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP  = 8'hDD;
    localparam logic [7:0] OPC_RD_BURST = 8'hEE;

    localparam int ALU_OPA_ADDR = 0;
    localparam int ALU_OPB_ADDR = 1;

    // States that wait on the next RX byte; only these may time out.
    function automatic logic is_byte_wait(input state_t s);
        return (s == S_WR_ADDR) || (s == S_WR_DATA) || (s == S_RD_ADDR) ||
               (s == S_RD_CNT)  || (s == S_OP_A)    || (s == S_OP_B)    ||
               (s == S_ALU_FN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_timeout_cnt.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | frame_timeout_cnt : idle-cycle counter, one-cycle expire pulse after   |
// |                     TMO_CYC enabled cycles without a clear             |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
module frame_timeout_cnt #(
    parameter int TMO_CYC = 1023
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    generate
        if (TMO_CYC == 0) begin : g_off
            logic w_unused;
            assign w_unused = clk_i ^ rst_ni ^ clr_i ^ en_i;
            assign expire_o = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TMO_CYC + 1);
            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                end else if (clr_i) begin
                    cnt_q <= '0;
                end else if (en_i) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            // Fires on the TMO_CYC-th consecutive idle cycle.
            assign expire_o = en_i & ~clr_i & (cnt_q == CW'(TMO_CYC - 1));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sys_ctrl_frame_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sys_ctrl_frame_engine : decodes RX command frames, drives RegFile and  |
// |                         ALU, streams results into the TX async FIFO    |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
module sys_ctrl_frame_engine
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int ALU_W   = 16,
    parameter int TMO_CYC = 1023
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] RX_P_DATA,
    input  logic              RX_D_VLD,
    input  logic              FIFO_FULL,
    output logic [DATA_W-1:0] TX_P_DATA,
    output logic              TX_D_VLD,
    output logic [ADDR_W-1:0] Address,
    output logic              WrEn,
    output logic              RdEn,
    output logic [DATA_W-1:0] WrData,
    input  logic [DATA_W-1:0] RdData,
    input  logic              RdData_Valid,
    output logic [3:0]        ALU_FUN,
    output logic              ALU_EN,
    output logic              CLK_Gate_EN,
    input  logic [ALU_W-1:0]  ALU_OUT,
    input  logic              ALU_OUT_Valid,
    output logic              FRM_ERR
);

    localparam int NB    = ALU_W / DATA_W;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNT_W = DATA_W + 1;

    generate
        if (ALU_W % DATA_W != 0) begin : g_bad_alu_w
            $error("ALU_W must be a multiple of DATA_W");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                burst_q, burst_d;
    logic [3:0]          fun_q, fun_d;
    logic [DATA_W-1:0]   rdat_q, rdat_d;
    logic [ALU_W-1:0]    res_q, res_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [DATA_W-1:0]   wrdata_q, wrdata_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic                rden_q;
    logic                alu_en_q;
    logic [3:0]          alu_fun_q;
    logic                cg_q;
    logic                frm_err_q, frm_err_d;

    logic                w_wait;
    logic                w_tmo_expire;
    logic                w_tx_state;
    logic [DATA_W-1:0]   w_alu_byte;

    assign w_wait = is_byte_wait(state_q);

    // Every entry into a byte-wait state coincides with an RX strobe, so
    // clearing on strobe or outside wait states also covers state entry.
    frame_timeout_cnt #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .clr_i    (RX_D_VLD | ~w_wait),
        .en_i     (w_wait),
        .expire_o (w_tmo_expire)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        burst_d   = burst_q;
        fun_d     = fun_q;
        rdat_d    = rdat_q;
        res_d     = res_q;
        idx_d     = idx_q;
        wren_d    = 1'b0;
        wr_addr_d = '0;
        wrdata_d  = '0;
        frm_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == DATA_W'(OPC_WR)) begin
                        state_d = S_WR_ADDR;
                    end else if (RX_P_DATA == DATA_W'(OPC_RD)) begin
                        state_d = S_RD_ADDR;
                        burst_d = 1'b0;
                    end else if (RX_P_DATA == DATA_W'(OPC_RD_BURST)) begin
                        state_d = S_RD_ADDR;
                        burst_d = 1'b1;
                    end else if (RX_P_DATA == DATA_W'(OPC_ALU_OP)) begin
                        state_d = S_OP_A;
                    end else if (RX_P_DATA == DATA_W'(OPC_ALU_NOP)) begin
                        state_d = S_ALU_FN;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end
            end
            S_WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_W-1:0];
                    state_d = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (RX_D_VLD) begin
                    wren_d    = 1'b1;
                    wr_addr_d = addr_q;
                    wrdata_d  = RX_P_DATA;
                    state_d   = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d = RX_P_DATA[ADDR_W-1:0];
                    if (burst_q) begin
                        state_d = S_RD_CNT;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_CNT: begin
                if (RX_D_VLD) begin
                    // A zero count byte requests the full 2^DATA_W burst.
                    cnt_d   = (RX_P_DATA == '0) ? CNT_W'(1 << DATA_W)
                                                : {1'b0, RX_P_DATA};
                    state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (RdData_Valid) begin
                    rdat_d  = RdData;
                    state_d = S_RD_SEND;
                end
            end
            S_RD_SEND: begin
                if (!FIFO_FULL) begin
                    addr_d  = addr_q + 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == CNT_W'(1)) ? S_IDLE : S_RD_REQ;
                end
            end
            S_OP_A: begin
                if (RX_D_VLD) begin
                    wren_d    = 1'b1;
                    wr_addr_d = ADDR_W'(ALU_OPA_ADDR);
                    wrdata_d  = RX_P_DATA;
                    state_d   = S_OP_B;
                end
            end
            S_OP_B: begin
                if (RX_D_VLD) begin
                    wren_d    = 1'b1;
                    wr_addr_d = ADDR_W'(ALU_OPB_ADDR);
                    wrdata_d  = RX_P_DATA;
                    state_d   = S_ALU_FN;
                end
            end
            S_ALU_FN: begin
                if (RX_D_VLD) begin
                    fun_d   = RX_P_DATA[3:0];
                    state_d = S_ALU_RUN;
                end
            end
            S_ALU_RUN: begin
                if (ALU_OUT_Valid) begin
                    res_d   = ALU_OUT;
                    idx_d   = '0;
                    state_d = S_ALU_SEND;
                end
            end
            S_ALU_SEND: begin
                if (!FIFO_FULL) begin
                    if (idx_q == IDX_W'(NB - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Expiry is masked by an RX strobe, so no write can be pending here.
        if (w_tmo_expire) begin
            state_d   = S_IDLE;
            frm_err_d = 1'b1;
        end
    end

    always_comb begin
        address_d = '0;
        if (wren_d) begin
            address_d = wr_addr_d;
        end else if (state_d == S_RD_REQ) begin
            address_d = addr_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            burst_q   <= 1'b0;
            fun_q     <= '0;
            rdat_q    <= '0;
            res_q     <= '0;
            idx_q     <= '0;
            wren_q    <= 1'b0;
            wrdata_q  <= '0;
            address_q <= '0;
            rden_q    <= 1'b0;
            alu_en_q  <= 1'b0;
            alu_fun_q <= '0;
            cg_q      <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            fun_q     <= fun_d;
            rdat_q    <= rdat_d;
            res_q     <= res_d;
            idx_q     <= idx_d;
            wren_q    <= wren_d;
            wrdata_q  <= wrdata_d;
            address_q <= address_d;
            rden_q    <= (state_d == S_RD_REQ);
            alu_en_q  <= (state_d == S_ALU_RUN);
            alu_fun_q <= (state_d == S_ALU_RUN) ? fun_d : 4'd0;
            cg_q      <= (state_d == S_ALU_FN) || (state_d == S_ALU_RUN) ||
                         (state_d == S_ALU_SEND);
            frm_err_q <= frm_err_d;
        end
    end

    // TX strobe stays combinational so FIFO_FULL gates it in the same cycle.
    assign w_alu_byte = res_q[int'(idx_q)*DATA_W +: DATA_W];
    assign w_tx_state = (state_q == S_RD_SEND) || (state_q == S_ALU_SEND);
    assign TX_D_VLD   = w_tx_state & ~FIFO_FULL;
    assign TX_P_DATA  = !TX_D_VLD ? '0 :
                        (state_q == S_RD_SEND) ? rdat_q : w_alu_byte;

    assign WrEn        = wren_q;
    assign WrData      = wrdata_q;
    assign Address     = address_q;
    assign RdEn        = rden_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = alu_fun_q;
    assign CLK_Gate_EN = cg_q;
    assign FRM_ERR     = frm_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_ctrl_frame_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sys_ctrl_frame_engine : directed frames against RegFile/ALU models  |
// |                            with TX and write scoreboards               |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
module tb_sys_ctrl_frame_engine;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 4;
    localparam int ALU_W   = 32;
    localparam int TMO_CYC = 40;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [DATA_W-1:0] RX_P_DATA = '0;
    logic              RX_D_VLD = 1'b0;
    logic              FIFO_FULL = 1'b0;
    logic [DATA_W-1:0] TX_P_DATA;
    logic              TX_D_VLD;
    logic [ADDR_W-1:0] Address;
    logic              WrEn;
    logic              RdEn;
    logic [DATA_W-1:0] WrData;
    logic [DATA_W-1:0] RdData = '0;
    logic              RdData_Valid = 1'b0;
    logic [3:0]        ALU_FUN;
    logic              ALU_EN;
    logic              CLK_Gate_EN;
    logic [ALU_W-1:0]  ALU_OUT;
    logic              ALU_OUT_Valid = 1'b0;
    logic              FRM_ERR;

    int n_cmp = 0;
    int n_err = 0;
    int tx_cnt = 0;

    logic [DATA_W-1:0]        mem [16];
    logic [ALU_W-1:0]         alu_val = '0;
    logic [3:0]               exp_fun = '0;
    logic [DATA_W-1:0]        exp_tx [$];
    logic [ADDR_W+DATA_W-1:0] exp_wr [$];

    sys_ctrl_frame_engine #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ALU_W   (ALU_W),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_P_DATA     (RX_P_DATA),
        .RX_D_VLD      (RX_D_VLD),
        .FIFO_FULL     (FIFO_FULL),
        .TX_P_DATA     (TX_P_DATA),
        .TX_D_VLD      (TX_D_VLD),
        .Address       (Address),
        .WrEn          (WrEn),
        .RdEn          (RdEn),
        .WrData        (WrData),
        .RdData        (RdData),
        .RdData_Valid  (RdData_Valid),
        .ALU_FUN       (ALU_FUN),
        .ALU_EN        (ALU_EN),
        .CLK_Gate_EN   (CLK_Gate_EN),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_Valid (ALU_OUT_Valid),
        .FRM_ERR       (FRM_ERR)
    );

    always #5 CLK = ~CLK;

    // RegFile model: one-cycle read latency, one response per request.
    always @(posedge CLK) begin
        RdData_Valid <= RdEn && !RdData_Valid;
        if (RdEn && !RdData_Valid) RdData <= mem[Address];
    end

    // ALU model: result valid one cycle after enable; junk otherwise.
    always @(posedge CLK) ALU_OUT_Valid <= ALU_EN && !ALU_OUT_Valid;
    assign ALU_OUT = ALU_OUT_Valid ? alu_val : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (RST) begin
            if (TX_D_VLD) begin
                logic [DATA_W-1:0] e;
                e = (exp_tx.size() > 0) ? exp_tx.pop_front() : 'x;
                chk("tx_not_full", FIFO_FULL, 0);
                chk("tx_byte", TX_P_DATA, e);
                tx_cnt++;
            end
            if (WrEn) begin
                logic [ADDR_W+DATA_W-1:0] w;
                w = (exp_wr.size() > 0) ? exp_wr.pop_front() : 'x;
                chk("write", {Address, WrData}, w);
            end
            if (ALU_EN) begin
                chk("alu_fun", ALU_FUN, exp_fun);
                chk("alu_clk_gate", CLK_Gate_EN, 1);
            end
        end
    end

    task automatic send(input logic [DATA_W-1:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD  = 1'b0;
        RX_P_DATA = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic drain(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && (exp_tx.size() > 0 || exp_wr.size() > 0); i++) tick(1);
        tick(1);
        chk(tag, exp_tx.size() + exp_wr.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx"}, {TX_D_VLD, TX_P_DATA}, 0);
        chk({tag, "_wr"}, {WrEn, RdEn, Address, WrData}, 0);
        chk({tag, "_alu"}, {ALU_EN, ALU_FUN, CLK_Gate_EN, FRM_ERR}, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h40 + i);
        mem[14] = 8'h11;
        mem[15] = 8'h22;
        mem[0]  = 8'h33;

        // Reset state
        tick(3);
        chk_all_zero("reset");
        @(posedge CLK); #1;
        RST = 1'b1;
        tick(2);

        // Single write with one-cycle latency
        exp_wr.push_back({4'h5, 8'h3C});
        send(8'hAA); send(8'h05); send(8'h3C);
        chk("wr_latency", {WrEn, Address, WrData}, {1'b1, 4'h5, 8'h3C});
        tick(1);
        chk("wr_one_cycle", {WrEn, Address, WrData}, 0);

        // Burst read wrapping E,F,0 with back-pressure after the first byte
        exp_tx.push_back(8'h11); exp_tx.push_back(8'h22); exp_tx.push_back(8'h33);
        tx_cnt = 0;
        send(8'hEE); send(8'h0E); send(8'h03);
        for (int i = 0; i < 50 && tx_cnt < 1; i++) tick(1);
        FIFO_FULL = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("no_tx_when_full", TX_D_VLD, 0);
        end
        FIFO_FULL = 1'b0;
        drain("burst_drain", 50);
        chk("burst_count", tx_cnt, 3);

        // ALU with operands; result captured once, sent LSB first
        exp_wr.push_back({4'h0, 8'h07}); exp_wr.push_back({4'h1, 8'h03});
        exp_fun = 4'h0;
        alu_val = 32'h1234_5678;
        exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
        send(8'hCC); send(8'h07); send(8'h03); send(8'h00);
        drain("alu_drain", 50);
        chk("alu_idle_gate", CLK_Gate_EN, 0);

        // Bad opcode, then a normal write
        send(8'h5A);
        chk("bad_opc_err", FRM_ERR, 1);
        tick(1);
        chk("bad_opc_pulse", FRM_ERR, 0);
        exp_wr.push_back({4'h3, 8'h99});
        send(8'hAA); send(8'h03); send(8'h99);
        drain("after_err_drain", 10);

        // Inter-byte timeout, then the late byte is an opcode error
        send(8'hAA); send(8'h02);
        n = 0;
        while (!FRM_ERR && n < TMO_CYC + 20) begin tick(1); n++; end
        chk("tmo_err", FRM_ERR, 1);
        chk("tmo_window", (n >= TMO_CYC && n <= TMO_CYC + 1), 1);
        send(8'h3C);
        chk("late_byte_err", FRM_ERR, 1);
        tick(2);

        // Async reset while ALU_SEND is stalled on a full FIFO
        FIFO_FULL = 1'b1;
        exp_fun = 4'h1;
        alu_val = 32'hCAFE_F00D;
        send(8'hDD); send(8'h01);
        tick(6);
        chk("stall_gate", CLK_Gate_EN, 1);
        FIFO_FULL = 1'b0;
        RST = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick(2);
        RST = 1'b1;
        tick(1);
        alu_val = 32'hA1B2_C3D4;
        exp_tx.push_back(8'hD4); exp_tx.push_back(8'hC3);
        exp_tx.push_back(8'hB2); exp_tx.push_back(8'hA1);
        send(8'hDD); send(8'h01);
        drain("post_rst_drain", 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
